id_decode_queue: RTL and testbench

- Parametrised successor to the single-entry ID stage. Decodes full RV32I (including FENCE/ECALL/EBREAK and illegal detection) into a DEPTH-entry decoded-op queue with valid/ready handshakes on both sides.
- Sits between the instruction queue (IQ) and the ISSUE stage. Decouples IQ pop from ROB/RS/LSB back-pressure, so no fetched instruction is dropped and no per-cycle stall bubble is inserted.

---
 rtl/id_decode_queue_pkg.sv | 81 ++++++++
 rtl/id_decode_comb.sv | 138 +++++++++++++
 rtl/id_decode_queue.sv | 122 ++++++++++++
 tb/tb_id_decode_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_decode_queue_pkg.sv
// Shared decode definitions: RV32I field constants, decoded-op encoding, queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_decode_queue_pkg;

    localparam int OP_SIZE       = 6;
    localparam int REG_ADDR_SIZE = 5;
    localparam int INST_SIZE     = 32;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // funct7
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // funct3, ALU group
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3, branch group
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct3, load/store width
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [OP_SIZE-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_e;

    typedef struct packed {
        logic [OP_SIZE-1:0]       op;
        logic [REG_ADDR_SIZE-1:0] rs1;
        logic [REG_ADDR_SIZE-1:0] rs2;
        logic [REG_ADDR_SIZE-1:0] rd;
        logic [31:0]              imm;
        logic                     en_1;
        logic                     en_2;
        logic                     illegal;
    } dec_t;

    typedef struct packed {
        dec_t                 dec;
        logic [31:0]          pc;
        logic [INST_SIZE-1:0] inst;
    } entry_t;

endpackage

// File: rtl/id_decode_comb.sv
// Combinational RV32I decoder: instruction word -> decoded op, register fields, immediate, illegal flag.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the enclosing queue decides when the result is captured.
module id_decode_comb
    import id_decode_queue_pkg::*;
(
    input  logic [INST_SIZE-1:0]     inst,
    output logic [OP_SIZE-1:0]       op,
    output logic [REG_ADDR_SIZE-1:0] rs1,
    output logic [REG_ADDR_SIZE-1:0] rs2,
    output logic [REG_ADDR_SIZE-1:0] rd,
    output logic [31:0]              imm,
    output logic                     en_1,
    output logic                     en_2,
    output logic                     illegal
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        op      = OP_NOP;
        rd      = inst[11:7];
        imm     = '0;
        en_1    = 1'b0;
        en_2    = 1'b0;
        illegal = 1'b0;
        case (opc)
            OPC_LUI:   begin op = OP_LUI;   imm = imm_u; end
            OPC_AUIPC: begin op = OP_AUIPC; imm = imm_u; end
            OPC_JAL:   begin op = OP_JAL;   imm = imm_j; end
            OPC_JALR:  begin op = OP_JALR;  imm = imm_i; en_1 = 1'b1; end
            OPC_BRANCH: begin
                imm = imm_b; rd = '0; en_1 = 1'b1; en_2 = 1'b1;
                case (f3)
                    F3_BEQ:  op = OP_BEQ;
                    F3_BNE:  op = OP_BNE;
                    F3_BLT:  op = OP_BLT;
                    F3_BGE:  op = OP_BGE;
                    F3_BLTU: op = OP_BLTU;
                    F3_BGEU: op = OP_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                imm = imm_i; en_1 = 1'b1;
                case (f3)
                    F3_B:    op = OP_LB;
                    F3_H:    op = OP_LH;
                    F3_W:    op = OP_LW;
                    F3_BU:   op = OP_LBU;
                    F3_HU:   op = OP_LHU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                imm = imm_s; rd = '0; en_1 = 1'b1; en_2 = 1'b1;
                case (f3)
                    F3_B:    op = OP_SB;
                    F3_H:    op = OP_SH;
                    F3_W:    op = OP_SW;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                imm = imm_i; en_1 = 1'b1;
                case (f3)
                    F3_ADD:  op = OP_ADDI;
                    F3_SLT:  op = OP_SLTI;
                    F3_SLTU: op = OP_SLTIU;
                    F3_XOR:  op = OP_XORI;
                    F3_OR:   op = OP_ORI;
                    F3_AND:  op = OP_ANDI;
                    // shifts reuse imm[11:5] as a funct7 qualifier
                    F3_SLL: begin
                        if (f7 == F7_BASE) op = OP_SLLI;
                        else               illegal = 1'b1;
                    end
                    F3_SR: begin
                        if (f7 == F7_BASE)     op = OP_SRLI;
                        else if (f7 == F7_ALT) op = OP_SRAI;
                        else                   illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP: begin
                en_1 = 1'b1; en_2 = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  op = OP_ADD;
                        F3_SLL:  op = OP_SLL;
                        F3_SLT:  op = OP_SLT;
                        F3_SLTU: op = OP_SLTU;
                        F3_XOR:  op = OP_XOR;
                        F3_SR:   op = OP_SRL;
                        F3_OR:   op = OP_OR;
                        F3_AND:  op = OP_AND;
                        default: illegal = 1'b1;
                    endcase
                end else if (f7 == F7_ALT) begin
                    case (f3)
                        F3_ADD:  op = OP_SUB;
                        F3_SR:   op = OP_SRA;
                        default: illegal = 1'b1;
                    endcase
                end else begin
                    illegal = 1'b1;
                end
            end
            // fence / ecall / ebreak retire as nops with no register traffic
            OPC_MISC_MEM, OPC_SYSTEM: rd = '0;
            default: illegal = 1'b1;
        endcase
        // an undecodable word must not read or write registers
        if (illegal) begin
            op   = OP_NOP;
            rd   = '0;
            en_1 = 1'b0;
            en_2 = 1'b0;
        end
    end

endmodule

// File: rtl/id_decode_queue.sv
// Decode stage: RV32I decode at the write side of a DEPTH-entry decoded-op queue (IQ -> ISSUE).
// Latency: 1 cycle, entry pushed at edge N is visible on the issue outputs after edge N.
// Backpressure: inst_ready = count<DEPTH (a same-cycle pop does not free a slot); pop on issue_valid&&issue_ready.
// Ports: clk_in/rst_in (async active-low), rdy_in freezes all state, clear flushes synchronously;
//        inst_valid/inst_ready/inst_in/pc_in from IQ; issue_valid/issue_ready plus head fields to ISSUE; count.
// Optional: define ID_STALL_CNT_EN to add stall_cnt (saturating count of blocked-head cycles, kept across clear).
module id_decode_queue
    import id_decode_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic                     inst_valid,
    input  logic [INST_SIZE-1:0]     inst_in,
    input  logic [31:0]              pc_in,
    output logic                     inst_ready,
    input  logic                     issue_ready,
    output logic                     issue_valid,
    output logic [OP_SIZE-1:0]       OpCode,
    output logic [REG_ADDR_SIZE-1:0] rs1,
    output logic [REG_ADDR_SIZE-1:0] rs2,
    output logic [REG_ADDR_SIZE-1:0] rd,
    output logic                     en_1,
    output logic                     en_2,
    output logic [31:0]              imm,
    output logic [31:0]              pc,
    output logic [INST_SIZE-1:0]     Inst_debug,
    output logic                     illegal,
    output logic [PTR_W:0]           count
`ifdef ID_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    dec_t             dec;
    entry_t           wr_entry;
    entry_t           head;
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop;

    id_decode_comb u_dec (
        .inst    (inst_in),
        .op      (dec.op),
        .rs1     (dec.rs1),
        .rs2     (dec.rs2),
        .rd      (dec.rd),
        .imm     (dec.imm),
        .en_1    (dec.en_1),
        .en_2    (dec.en_2),
        .illegal (dec.illegal)
    );

    assign wr_entry = '{dec: dec, pc: pc_in, inst: inst_in};

    assign inst_ready  = (count < CNT_FULL);
    assign issue_valid = (count != '0);
    assign push = inst_valid && inst_ready && rdy_in && !clear;
    assign pop  = issue_valid && issue_ready && rdy_in && !clear;

    // DEPTH is a power of two, so pointer wrap is plain overflow
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= wr_entry;
                    wr_ptr      <= wr_ptr + PTR_ONE;
                end
                if (pop) rd_ptr <= rd_ptr + PTR_ONE;
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    assign head       = mem[rd_ptr];
    assign OpCode     = head.dec.op;
    assign rs1        = head.dec.rs1;
    assign rs2        = head.dec.rs2;
    assign rd         = head.dec.rd;
    assign imm        = head.dec.imm;
    assign en_1       = head.dec.en_1;
    assign en_2       = head.dec.en_2;
    assign illegal    = head.dec.illegal;
    assign pc         = head.pc;
    assign Inst_debug = head.inst;

`ifdef ID_STALL_CNT_EN
    // counts cycles where ISSUE back-pressure holds a valid head; clear does not touch it
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_cnt <= '0;
        end else if (rdy_in && issue_valid && !issue_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    // no stall instrumentation in this build
`endif

endmodule

// File: tb/tb_id_decode_queue.sv
module tb_id_decode_queue;
    import id_decode_queue_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, inst_valid, issue_ready;
    logic [31:0] inst_in, pc_in;
    logic        inst_ready, issue_valid, en_1, en_2, illegal;
    logic [5:0]  OpCode;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pc, Inst_debug;
    logic [2:0]  count;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk_in = ~clk_in;

    id_decode_queue #(.DEPTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .inst_valid(inst_valid), .inst_in(inst_in), .pc_in(pc_in), .inst_ready(inst_ready),
        .issue_ready(issue_ready), .issue_valid(issue_valid), .OpCode(OpCode),
        .rs1(rs1), .rs2(rs2), .rd(rd), .en_1(en_1), .en_2(en_2), .imm(imm), .pc(pc),
        .Inst_debug(Inst_debug), .illegal(illegal), .count(count)
`ifdef ID_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        logic [31:0] inst;
        logic [5:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        ci, en1, en2, ill;
        logic [31:0] pc;
    } exp_t;

    exp_t tbl[$];
    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic exp_t mk(logic [31:0] inst, logic [5:0] op, logic [4:0] r1, logic [4:0] r2,
                                logic [4:0] rdd, logic [31:0] im, logic ci, logic e1, logic e2, logic il);
        exp_t e;
        e.inst = inst; e.op = op; e.rs1 = r1; e.rs2 = r2; e.rd = rdd; e.imm = im;
        e.ci = ci; e.en1 = e1; e.en2 = e2; e.ill = il; e.pc = '0;
        return e;
    endfunction

    task automatic build_table();
        //            inst          op        rs1 rs2 rd  imm            ci e1 e2 ill
        tbl.push_back(mk(32'h00500093, OP_ADDI,  0, 0, 1, 32'h00000005, 1, 1, 0, 0));
        tbl.push_back(mk(32'hFE21AE23, OP_SW,    3, 2, 0, 32'hFFFFFFFC, 1, 1, 1, 0));
        tbl.push_back(mk(32'hFE000CE3, OP_BEQ,   0, 0, 0, 32'hFFFFFFF8, 1, 1, 1, 0));
        tbl.push_back(mk(32'h123452B7, OP_LUI,   0, 0, 5, 32'h12345000, 1, 0, 0, 0));
        tbl.push_back(mk(32'h0000007F, OP_NOP,   0, 0, 0, 32'h0,        0, 0, 0, 1));
        tbl.push_back(mk(32'h4000E033, OP_NOP,   0, 0, 0, 32'h0,        0, 0, 0, 1));
        tbl.push_back(mk(32'h002081B3, OP_ADD,   1, 2, 3, 32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(32'h402081B3, OP_SUB,   1, 2, 3, 32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(32'h008000EF, OP_JAL,   0, 0, 1, 32'h00000008, 1, 0, 0, 0));
        tbl.push_back(mk(32'h00812203, OP_LW,    2, 0, 4, 32'h00000008, 1, 1, 0, 0));
        tbl.push_back(mk(32'h00000073, OP_NOP,   0, 0, 0, 32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(32'h0FF0000F, OP_NOP,   0, 0, 0, 32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(32'h00813203, OP_NOP,   0, 0, 0, 32'h0,        0, 0, 0, 1));
        tbl.push_back(mk(32'h40109093, OP_NOP,   0, 0, 0, 32'h0,        0, 0, 0, 1));
        tbl.push_back(mk(32'h4010D093, OP_SRAI,  1, 0, 1, 32'h00000401, 1, 1, 0, 0));
        tbl.push_back(mk(32'h022081B3, OP_NOP,   0, 0, 0, 32'h0,        0, 0, 0, 1));
        tbl.push_back(mk(32'hFE21BE23, OP_NOP,   0, 0, 0, 32'h0,        0, 0, 0, 1));
        tbl.push_back(mk(32'hFE002CE3, OP_NOP,   0, 0, 0, 32'h0,        0, 0, 0, 1));
        tbl.push_back(mk(32'h00001097, OP_AUIPC, 0, 0, 1, 32'h00001000, 1, 0, 0, 0));
        tbl.push_back(mk(32'h00008067, OP_JALR,  1, 0, 0, 32'h00000000, 1, 1, 0, 0));
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        n_total++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
        n_total++; if (issue_valid !== 1'b0) $display("FAIL reset_issue_valid got %b want 0", issue_valid); else n_pass++;
        n_total++; if (inst_ready !== 1'b1) $display("FAIL reset_inst_ready got %b want 1", inst_ready); else n_pass++;
        n_total++;
        if ({OpCode, rd, imm, pc, Inst_debug, illegal} !== '0)
            $display("FAIL reset_head got op=%0d rd=%0d imm=%h pc=%h inst=%h ill=%b want all 0",
                     OpCode, rd, imm, pc, Inst_debug, illegal);
        else n_pass++;
        rst_in = 1'b1;
        @(negedge clk_in);
        n_total++; if (count !== 3'd0) $display("FAIL post_reset_count got %0d want 0", count); else n_pass++;
    endtask

    // Streams n table entries; ISSUE is blocked for the first 'hold' cycles.
    task automatic test_queue_stream(input int n, input int hold);
        int   j = 0, popped = 0, cyc = 0, pre;
        exp_t e, h;
        while ((j < n || sb.size() != 0) && cyc < 200) begin
            issue_ready = (cyc >= hold);
            inst_valid  = (j < n);
            inst_in     = (j < n) ? tbl[j].inst : 32'h0;
            pc_in       = 32'h1000 + 32'(4 * j);
            pre = sb.size();
            n_total++;
            if (count !== 3'(pre) || inst_ready !== (pre < 4) || issue_valid !== (pre != 0))
                $display("FAIL occupancy cyc=%0d got count=%0d rdy=%b vld=%b want count=%0d", cyc, count, inst_ready, issue_valid, pre);
            else n_pass++;
            if (hold > 0 && cyc == hold) begin
                n_total++;
                if (count !== 3'd4 || inst_ready !== 1'b0) $display("FAIL full_stall got count=%0d rdy=%b want 4/0", count, inst_ready);
                else n_pass++;
            end
            if (pre != 0 && issue_ready) begin
                h = sb.pop_front();
                popped++;
                n_total++;
                if (OpCode !== h.op || illegal !== h.ill || en_1 !== h.en1 || en_2 !== h.en2 ||
                    pc !== h.pc || Inst_debug !== h.inst || (!h.ill && rd !== h.rd) ||
                    (h.en1 && rs1 !== h.rs1) || (h.en2 && rs2 !== h.rs2) || (h.ci && imm !== h.imm))
                    $display("FAIL head inst=%h got op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h e=%b%b ill=%b pc=%h raw=%h want op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h e=%b%b ill=%b pc=%h",
                             h.inst, OpCode, rd, rs1, rs2, imm, en_1, en_2, illegal, pc, Inst_debug,
                             h.op, h.rd, h.rs1, h.rs2, h.imm, h.en1, h.en2, h.ill, h.pc);
                else n_pass++;
            end
            if (j < n && pre < 4) begin
                e = tbl[j];
                e.pc = pc_in;
                sb.push_back(e);
                j++;
            end
            @(negedge clk_in);
            cyc++;
        end
        inst_valid = 1'b0; issue_ready = 1'b0;
        n_total++;
        if (popped != n || cyc >= 200) $display("FAIL stream_drain got popped=%0d cyc=%0d want popped=%0d", popped, cyc, n);
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_freeze();
        inst_valid = 1'b1; inst_in = tbl[0].inst; pc_in = 32'h2000; issue_ready = 1'b0;
        @(negedge clk_in);
        rdy_in = 1'b0; inst_in = tbl[1].inst; issue_ready = 1'b1;
        repeat (2) @(negedge clk_in);
        clear = 1'b1;
        @(negedge clk_in);
        n_total++;
        if (count !== 3'd1 || Inst_debug !== tbl[0].inst) $display("FAIL freeze got count=%0d inst=%h want 1/%h", count, Inst_debug, tbl[0].inst);
        else n_pass++;
        rdy_in = 1'b1; clear = 1'b0; inst_valid = 1'b0;
        @(negedge clk_in);
        n_total++; if (count !== 3'd0) $display("FAIL unfreeze_pop got count=%0d want 0", count); else n_pass++;
        issue_ready = 1'b0;
    endtask

    task automatic test_clear();
        issue_ready = 1'b0;
        for (int k = 6; k < 9; k++) begin
            inst_valid = 1'b1; inst_in = tbl[k].inst; pc_in = 32'h3000 + 32'(4 * k);
            @(negedge clk_in);
        end
        n_total++; if (count !== 3'd3) $display("FAIL clear_fill got count=%0d want 3", count); else n_pass++;
        clear = 1'b1; inst_in = tbl[9].inst;
        @(negedge clk_in);
        clear = 1'b0; inst_valid = 1'b0;
        n_total++;
        if (count !== 3'd0 || issue_valid !== 1'b0 || inst_ready !== 1'b1)
            $display("FAIL clear got count=%0d vld=%b rdy=%b want 0/0/1", count, issue_valid, inst_ready);
        else n_pass++;
        @(negedge clk_in);
        n_total++; if (count !== 3'd0) $display("FAIL clear_discard got count=%0d want 0", count); else n_pass++;
        inst_valid = 1'b1; inst_in = tbl[3].inst; pc_in = 32'h4000;
        @(negedge clk_in);
        inst_valid = 1'b0;
        n_total++;
        if (count !== 3'd1 || Inst_debug !== tbl[3].inst || imm !== 32'h12345000)
            $display("FAIL after_clear got count=%0d inst=%h imm=%h want 1/%h/12345000", count, Inst_debug, imm, tbl[3].inst);
        else n_pass++;
        issue_ready = 1'b1;
        @(negedge clk_in);
        issue_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            inst_valid = 1'b1; inst_in = tbl[k].inst; pc_in = 32'h5000 + 32'(4 * k);
            @(negedge clk_in);
        end
        inst_valid = 1'b0;
        #2 rst_in = 1'b0;
        #1;
        n_total++;
        if (count !== 3'd0 || issue_valid !== 1'b0 || Inst_debug !== 32'h0)
            $display("FAIL async_reset got count=%0d vld=%b inst=%h want 0/0/0", count, issue_valid, Inst_debug);
        else n_pass++;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        n_total++;
        if (count !== 3'd0 || inst_ready !== 1'b1) $display("FAIL async_release got count=%0d rdy=%b want 0/1", count, inst_ready);
        else n_pass++;
    endtask

`ifdef ID_STALL_CNT_EN
    task automatic test_stall_cnt();
        n_total++; if (stall_cnt !== 32'd0) $display("FAIL stall_reset got %0d want 0", stall_cnt); else n_pass++;
        issue_ready = 1'b0; inst_valid = 1'b1; inst_in = tbl[0].inst; pc_in = 32'h6000;
        @(negedge clk_in);
        inst_valid = 1'b0;
        repeat (10) @(negedge clk_in);
        n_total++; if (stall_cnt !== 32'd10) $display("FAIL stall_cnt got %0d want 10", stall_cnt); else n_pass++;
        clear = 1'b1; issue_ready = 1'b1;
        @(negedge clk_in);
        clear = 1'b0; issue_ready = 1'b0;
        @(negedge clk_in);
        n_total++;
        if (stall_cnt !== 32'd10 || count !== 3'd0) $display("FAIL stall_keep got cnt=%0d count=%0d want 10/0", stall_cnt, count);
        else n_pass++;
    endtask
`endif

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; inst_valid = 1'b0; issue_ready = 1'b0;
        inst_in = '0; pc_in = '0;
        build_table();
        test_reset();
        test_queue_stream(tbl.size(), 0);
        test_queue_stream(6, 6);
        test_freeze();
        test_clear();
        test_async_reset();
`ifdef ID_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
